// File: rtl/main_mem_responder.sv
// main_mem_responder: multi-cycle main memory model; block read bursts after a fixed latency, acked word writes.
// Optional MEM_CRITICAL_WORD_FIRST_EN: bursts start at the requested word and wrap at the block boundary.
module main_mem_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [15:0]           rsp_data,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  rsp_last,
    output logic                  wr_ack
);
    localparam int OW = $clog2(BLOCK_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [OW-1:0]         beat_q, beat_d, start_q, start_d, req_start, off;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  wr_ack_q;
    logic                  accept;
    logic                  unused_bits;
    logic [15:0]           mem [2**(ADDR_WIDTH-1)];
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    assign req_start = req_addr[OW:1];
`else
    assign req_start = '0;
`endif
    assign unused_bits = ^req_addr[OW:0];
    assign accept      = req_valid && state_q == IDLE;
    assign off         = start_q + beat_q;
    assign req_ready   = state_q == IDLE;
    assign rsp_valid   = state_q == BURST;
    assign rsp_addr    = rsp_valid ? base_q | {{(ADDR_WIDTH-OW-1){1'b0}}, off, 1'b0} : '0;
    assign rsp_data    = rsp_valid ? mem[rsp_addr[ADDR_WIDTH-1:1]] : '0;
    assign rsp_last    = rsp_valid && beat_q == OW'(BLOCK_WORDS-1);
    assign wr_ack      = wr_ack_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        start_d = start_q;
        base_d  = base_q;
        if (accept && !req_write) begin
            base_d  = {req_addr[ADDR_WIDTH-1:OW+1], {(OW+1){1'b0}}};
            start_d = req_start;
            cnt_d   = 4'(LATENCY-1);
            beat_d  = '0;
            state_d = (LATENCY == 1) ? BURST : WAIT;
        end else if (state_q == WAIT) begin
            // leaving on 1 puts the first beat exactly LATENCY cycles after acceptance
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? BURST : WAIT;
        end else if (state_q == BURST) begin
            beat_d  = beat_q + 1'b1;
            state_d = rsp_last ? IDLE : BURST;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            start_q  <= '0;
            base_q   <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            start_q  <= start_d;
            base_q   <= base_d;
            wr_ack_q <= accept && req_write;
        end
    end
    always_ff @(posedge clk) begin
        if (accept && req_write) mem[req_addr[ADDR_WIDTH-1:1]] <= req_wdata;
    end
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed bench for main_mem_responder at default parameters.
module tb_main_mem_responder;
    localparam int LAT = 4;
    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_last, wr_ack;
    logic [15:0] rsp_data, rsp_addr;
    int          tests = 0, fails = 0;
    logic [15:0] mdl [int];

    always #5 clk = ~clk;

    main_mem_responder #(.ADDR_WIDTH(16), .LATENCY(LAT), .BLOCK_WORDS(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .rsp_last(rsp_last), .wr_ack(wr_ack)
    );

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        mdl[int'(addr)] = data;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic read_burst(input logic [15:0] addr, output logic [7:0][15:0] a,
                              output logic [7:0][15:0] d, output logic [7:0] l, output int err);
        err = 0;
        if (req_ready !== 1'b1) err++;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (LAT-1) begin
            if (rsp_valid !== 1'b0 || req_ready !== 1'b0) err++;
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0) err++;
            a[i] = rsp_addr; d[i] = rsp_data; l[i] = rsp_last;
            @(negedge clk);
        end
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) err++;
    endtask

    function automatic logic [7:0][15:0] model_data(input logic [7:0][15:0] e);
        logic [7:0][15:0] r;
        for (int i = 0; i < 8; i++) r[i] = mdl.exists(int'(e[i])) ? mdl[int'(e[i])] : 16'hxxxx;
        return r;
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++;
        if ({req_ready, rsp_valid, rsp_last, wr_ack, rsp_data, rsp_addr} !== {4'b1000, 32'h0}) begin
            fails++;
            $display("FAIL reset_vals: got rdy=%b v=%b last=%b ack=%b data=%h addr=%h want 1 0 0 0 0000 0000",
                     req_ready, rsp_valid, rsp_last, wr_ack, rsp_data, rsp_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
    endtask

    task automatic test_write_then_read;
        logic [7:0][15:0] a, d, e;
        logic [7:0] l;
        int err;
        for (int i = 0; i < 8; i++) begin
            wr(16'h0040 + 16'(2*i), 16'hA000 + 16'(i));
            tests++;
            if ({wr_ack, req_ready} !== 2'b11) begin
                fails++; $display("FAIL fill_ack%0d: got ack=%b rdy=%b want 1 1", i, wr_ack, req_ready);
            end
        end
        wr(16'h0046, 16'hBEEF);
        tests++;
        if (wr_ack !== 1'b1) begin fails++; $display("FAIL beef_ack: got %b want 1", wr_ack); end
        read_burst(16'h0040, a, d, l, err);
        e = {16'h4E, 16'h4C, 16'h4A, 16'h48, 16'h46, 16'h44, 16'h42, 16'h40};
        tests++;
        if (err !== 0) begin fails++; $display("FAIL rd40_timing: got %0d errors want 0", err); end
        tests++;
        if (a !== e) begin fails++; $display("FAIL rd40_addr: got %h want %h", a, e); end
        tests++;
        if (d !== model_data(e)) begin fails++; $display("FAIL rd40_data: got %h want %h", d, model_data(e)); end
        tests++;
        if (d[3] !== 16'hBEEF) begin fails++; $display("FAIL rd40_beef: got %h want beef", d[3]); end
        tests++;
        if (l !== 8'b1000_0000) begin fails++; $display("FAIL rd40_last: got %b want 10000000", l); end
    endtask

    task automatic test_wrap_order;
        logic [7:0][15:0] a, d, e;
        logic [7:0] l;
        int err;
        read_burst(16'h004C, a, d, l, err);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
        e = {16'h4A, 16'h48, 16'h46, 16'h44, 16'h42, 16'h40, 16'h4E, 16'h4C};
`else
        e = {16'h4E, 16'h4C, 16'h4A, 16'h48, 16'h46, 16'h44, 16'h42, 16'h40};
`endif
        tests++;
        if (err !== 0) begin fails++; $display("FAIL rd4c_timing: got %0d errors want 0", err); end
        tests++;
        if (a !== e) begin fails++; $display("FAIL rd4c_addr: got %h want %h", a, e); end
        tests++;
        if (d !== model_data(e)) begin fails++; $display("FAIL rd4c_data: got %h want %h", d, model_data(e)); end
        tests++;
        if (l !== 8'b1000_0000) begin fails++; $display("FAIL rd4c_last: got %b want 10000000", l); end
    endtask

    task automatic test_back_to_back;
        logic [12:1] rdy;
        int beats = 0;
        logic early = 1'b0;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready0: got %b want 1", req_ready); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            rdy[k] = req_ready;
            if (k < 12 && rsp_valid === 1'b1) beats++;
        end
        tests++;
        if (rdy !== 12'h800) begin fails++; $display("FAIL b2b_ready: got %b want 100000000000", rdy); end
        tests++;
        if (beats !== 8) begin fails++; $display("FAIL b2b_beats: got %0d want 8", beats); end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) begin
            early = early | rsp_valid;
            @(negedge clk);
        end
        tests++;
        if ({early, rsp_valid, rsp_addr} !== {2'b01, 16'h0040}) begin
            fails++; $display("FAIL b2b_second_start: got early=%b v=%b addr=%h want 0 1 0040", early, rsp_valid, rsp_addr);
        end
        repeat (8) @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle: got %b want 1", req_ready); end
    endtask

    task automatic test_reset_mid_burst;
        logic [7:0][15:0] a, d, e;
        logic [7:0] l;
        int err;
        int stray = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if ({rsp_valid, rsp_addr} !== {1'b1, 16'h0046}) begin
            fails++; $display("FAIL beat3: got v=%b addr=%h want 1 0046", rsp_valid, rsp_addr);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({req_ready, rsp_valid, rsp_last, rsp_data, rsp_addr} !== {3'b100, 32'h0}) begin
            fails++;
            $display("FAIL async_reset: got rdy=%b v=%b last=%b data=%h addr=%h want 1 0 0 0000 0000",
                     req_ready, rsp_valid, rsp_last, rsp_data, rsp_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) stray++;
        end
        tests++;
        if (stray !== 0) begin fails++; $display("FAIL stray_beats: got %0d want 0", stray); end
        read_burst(16'h0040, a, d, l, err);
        e = {16'h4E, 16'h4C, 16'h4A, 16'h48, 16'h46, 16'h44, 16'h42, 16'h40};
        tests++;
        if (err !== 0) begin fails++; $display("FAIL post_rst_timing: got %0d errors want 0", err); end
        tests++;
        if (a !== e || d !== model_data(e)) begin
            fails++; $display("FAIL post_rst_burst: got addr=%h data=%h want addr=%h data=%h", a, d, e, model_data(e));
        end
    endtask

    task automatic test_consecutive_writes;
        logic [7:0][15:0] a, d;
        logic [7:0] l;
        int err;
        wr(16'h0010, 16'h1111);
        tests++;
        if (wr_ack !== 1'b1) begin fails++; $display("FAIL cw_ack1: got %b want 1", wr_ack); end
        wr(16'h0012, 16'h2222);
        tests++;
        if (wr_ack !== 1'b1) begin fails++; $display("FAIL cw_ack2: got %b want 1", wr_ack); end
        @(negedge clk);
        tests++;
        if (wr_ack !== 1'b0) begin fails++; $display("FAIL cw_ack_drop: got %b want 0", wr_ack); end
        read_burst(16'h0010, a, d, l, err);
        tests++;
        if (err !== 0) begin fails++; $display("FAIL cw_timing: got %0d errors want 0", err); end
        tests++;
        if ({a[1], a[0], d[1], d[0]} !== {16'h0012, 16'h0010, 16'h2222, 16'h1111}) begin
            fails++; $display("FAIL cw_data: got %h %h %h %h want 0012 0010 2222 1111", a[1], a[0], d[1], d[0]);
        end
    endtask

    initial begin
        test_reset;
        test_write_then_read;
        test_wrap_order;
        test_back_to_back;
        test_reset_mid_burst;
        test_consecutive_writes;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
